// File: rtl/sqrt_lut_ctrl.sv
// LUT-based integer square root: normalises the input into ROM range by even shifts,
// rescales the ROM output by the matching half-shift, and buffers results in a credit-guarded FIFO.
module sqrt_lut_ctrl #(
    parameter int IN_WIDTH   = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 10,
    parameter int FRAC_BITS  = 4,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int SHIFT_MAX = IN_WIDTH - ADDR_WIDTH;
    localparam int K_MAX     = SHIFT_MAX / 2;
    localparam int K_W       = $clog2(K_MAX + 2);
    localparam int RW        = DATA_WIDTH + K_MAX + 2;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int SUM_W     = $clog2(2 * FIFO_DEPTH + 1);

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_found;
    logic [K_W-1:0]        w_k;
    logic [RW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_res;
    logic [SUM_W-1:0]      w_inflight;

    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [ROM_LAT:0]      r_pv;
    logic [K_W-1:0]        r_pk [ROM_LAT+1];
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [SUM_W-1:0]      r_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_wr      = r_pv[ROM_LAT];
    assign out_valid = (r_cnt != '0);
    assign w_pop     = out_valid & out_ready;
    assign rom_addr  = r_rom_addr;
    assign out_data  = out_valid ? r_mem[r_rptr] : '0;

    // Smallest even shift that brings the sample into ROM range; k is half of it.
    always_comb begin
        w_k     = K_W'(K_MAX);
        w_found = 1'b0;
        for (int unsigned i = 0; i <= unsigned'(K_MAX); i++) begin
            if (!w_found && ((in_data >> (2 * i + ADDR_WIDTH)) == '0)) begin
                w_k     = K_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pv       <= '0;
            r_rom_addr <= '0;
        end else begin
            r_pv <= {r_pv[ROM_LAT-1:0], w_accept};
            if (w_accept)
                r_rom_addr <= ADDR_WIDTH'(in_data >> {w_k, 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        r_pk[0] <= w_k;
        for (int unsigned i = 1; i <= unsigned'(ROM_LAT); i++)
            r_pk[i] <= r_pk[i-1];
    end

    // sqrt(a*4^k) = sqrt(a)*2^k: scale the fixed-point ROM value back, then round off the fraction.
    always_comb begin
        w_sum = ((RW'(rom_rd_data) << r_pk[ROM_LAT]) + ((RW'(1) << FRAC_BITS) >> 1)) >> FRAC_BITS;
        w_res = (|w_sum[RW-1:DATA_WIDTH]) ? '1 : w_sum[DATA_WIDTH-1:0];
    end

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i <= unsigned'(ROM_LAT); i++)
            if (r_pv[i])
                w_inflight = w_inflight + SUM_W'(1);
    end

    // Credit counts every sample already committed to reach the FIFO, so it can never overflow.
    assign in_ready = rst_n && ((r_cnt + w_inflight) < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + SUM_W'(1);
                2'b01:   r_cnt <= r_cnt - SUM_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_lut_ctrl.sv
// Bench for sqrt_lut_ctrl: default instance plus a ROM_LAT=2 / FIFO_DEPTH=8 instance,
// both scored against an arithmetic square-root reference with behavioural ROM models.
module tb_sqrt_lut_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [19:0] in_data;
    logic [9:0] rom_addr, rom_rd_data, out_data;
    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [19:0] in_data2;
    logic [9:0] rom_addr2, rom_rd_data2, out_data2, rom2_s1;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc;
    logic [9:0] exp_q[$];
    logic [9:0] exp_q2[$];
    logic       stall1, stall2;
    logic [9:0] held1, held2;

    sqrt_lut_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    sqrt_lut_ctrl #(.ROM_LAT(2), .FIFO_DEPTH(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .rom_addr(rom_addr2), .rom_rd_data(rom_rd_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2)
    );

    // ROM contents: floor(sqrt(a) * 16) == isqrt(a * 256)
    function automatic int unsigned rom_val(input int unsigned a);
        int unsigned x = a << 8;
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    always @(posedge clk) begin
        rom_rd_data  <= 10'(rom_val(32'(rom_addr)));
        rom2_s1      <= 10'(rom_val(32'(rom_addr2)));
        rom_rd_data2 <= rom2_s1;
    end

    function automatic logic [9:0] ref_sqrt(input logic [19:0] x);
        int unsigned s = 0;
        longint r;
        while (s < 10 && (x >> s) >= 20'd1024) s += 2;
        r = ((longint'(rom_val(32'(x >> s))) << (s / 2)) + 8) >> 4;
        if (r > 1023) r = 1023;
        return r[9:0];
    endfunction

    function automatic logic [19:0] rnd_in();
        logic [31:0] x;
        x = $urandom;
        return 20'(x >> $urandom_range(12, 31));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready", 64'(in_ready), 0);
            chk("rst_in_ready2", 64'(in_ready2), 0);
            exp_q.delete();
            exp_q2.delete();
            stall1 = 1'b0;
            stall2 = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                chk("credit", 64'(exp_q.size() < 4), 1);
                exp_q.push_back(ref_sqrt(in_data));
                n_acc++;
            end
            if (in_valid2 && in_ready2) begin
                chk("credit2", 64'(exp_q2.size() < 8), 1);
                exp_q2.push_back(ref_sqrt(in_data2));
            end
            if (stall1) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_data", 64'(out_data), 64'(held1));
            end
            if (stall2) begin
                chk("hold_valid2", 64'(out_valid2), 1);
                chk("hold_data2", 64'(out_data2), 64'(held2));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 0);
                else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (out_valid2 && out_ready2) begin
                if (exp_q2.size() == 0) chk("spurious_out2", 64'(out_valid2), 0);
                else chk("out_data2", 64'(out_data2), 64'(exp_q2.pop_front()));
            end
            stall1 = out_valid && !out_ready;
            held1  = out_data;
            stall2 = out_valid2 && !out_ready2;
            held2  = out_data2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [19:0] x, input int exp_addr, input int exp_out);
        chk("one_ready", 64'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        chk("one_addr", 64'(rom_addr), 64'(exp_addr));
        chk("lat_T0", 64'(out_valid), 0);
        step();
        chk("lat_T1", 64'(out_valid), 0);
        step();
        chk("lat_T2", 64'(out_valid), 1);
        chk("one_out", 64'(out_data), 64'(exp_out));
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) step();
        chk("drain_q", 64'(exp_q.size()), 0);
        chk("drain_q2", 64'(exp_q2.size()), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        stall1 = 1'b0; stall2 = 1'b0; held1 = '0; held2 = '0; n_acc = 0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_rom_addr", 64'(rom_addr), 0);
        chk("rst_out_valid2", 64'(out_valid2), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 1);
        chk("rel_in_ready2", 64'(in_ready2), 1);

        run_one(20'd900, 900, 30);
        run_one(20'd90000, 351, 299);
        run_one(20'd1048575, 1023, 1022);
        run_one(20'd0, 0, 0);

        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_in();
            chk("b2b_ready", 64'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        n_acc     = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = rnd_in();
            step();
        end
        chk("stall_accepts", 64'(n_acc), 4);
        chk("stall_ready", 64'(in_ready), 0);
        chk("stall_valid", 64'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = rnd_in();
            out_ready  = 1'($urandom_range(0, 1));
            in_valid2  = 1'($urandom_range(0, 1));
            in_data2   = rnd_in();
            out_ready2 = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        drain();

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rnd_in();
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        chk("midrst_out_valid", 64'(out_valid), 0);
        chk("midrst_out_data", 64'(out_data), 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 1);
        for (int i = 0; i < 10; i++) step();
        chk("midrst_idle_valid", 64'(out_valid), 0);
        run_one(20'd900, 900, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
